// File: rtl/aes_sched_pkg.sv
// Shared types for the AES pipeline scheduler: FSM states, FIFO entry and core latency.
// Used with and without AES_SCHED_KEY_RELOAD_EN.
package aes_sched_pkg;

  localparam int unsigned NR_AES      = 10;
  localparam int unsigned SCHED_ID_W  = 2;
  localparam int unsigned SCHED_TAG_W = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [127:0]            data;
    logic [SCHED_ID_W-1:0]  id;
    logic [SCHED_TAG_W-1:0] tag;
  } rsp_entry_t;

endpackage

// File: rtl/aes_sched_fifo.sv
// Synchronous response FIFO of rsp_entry_t with occupancy count; push+pop when full is legal.
module aes_sched_fifo
  import aes_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  rsp_entry_t       wdata_i,
  input  logic             pop_i,
  output rsp_entry_t       rdata_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  rsp_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Upstream credits make a push into a full FIFO without a pop unreachable.
      assert (!(push_i && full && !do_pop));
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/aes_pipe_sched.sv
// Round-robin scheduler feeding a non-stallable AES-128 pipeline, with credit-guarded response FIFO.
// Optional key reload FSM enabled by defining AES_SCHED_KEY_RELOAD_EN.
module aes_pipe_sched
  import aes_sched_pkg::*;
#(
  parameter int unsigned  NUM_REQ     = 4,
  parameter int unsigned  TAG_W       = SCHED_TAG_W,
  parameter int unsigned  LAT         = NR_AES,
  parameter int unsigned  FIFO_DEPTH  = 16,
  parameter logic [127:0] KEY_DEFAULT = 128'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*128-1:0]     req_data_i,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag_i,
  output logic [127:0]               core_state_o,
  output logic [127:0]               core_key_o,
  input  logic [127:0]               core_out_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [127:0]               rsp_data_o,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic [TAG_W-1:0]           rsp_tag_o
`ifdef AES_SCHED_KEY_RELOAD_EN
  ,
  input  logic                       key_upd_valid_i,
  input  logic [127:0]               key_upd_data_i,
  output logic                       key_upd_ready_o
`endif
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]  rr_q, rr_d, win;
  logic             any_valid, run_ok, credit_ok, accept;
  logic [LAT-1:0]   pv_q;
  logic [ID_W-1:0]  pid_q  [LAT];
  logic [TAG_W-1:0] ptag_q [LAT];
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  rsp_entry_t       push_entry, head_entry;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_valid && req_valid_i[ID_W'((32'(rr_q) + i) % NUM_REQ)]) begin
        any_valid = 1'b1;
        win       = ID_W'((32'(rr_q) + i) % NUM_REQ);
      end
    end
  end

  // Every accepted block eventually lands in the FIFO, so reserve room up front.
  assign credit_ok    = (32'(fifo_count) + 32'($countones(pv_q))) < FIFO_DEPTH;
  assign accept       = any_valid && run_ok && credit_ok;
  assign req_ready_o  = accept ? (NUM_REQ'(1) << win) : '0;
  assign core_state_o = accept ? req_data_i[32'(win)*128 +: 128] : '0;

  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = (32'(win) == NUM_REQ - 1) ? '0 : win + ID_W'(1);
  end

  // Sideband pipe mirroring the core stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
      pv_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        pid_q[i]  <= '0;
        ptag_q[i] <= '0;
      end
    end else begin
      rr_q      <= rr_d;
      pv_q      <= {pv_q[LAT-2:0], accept};
      pid_q[0]  <= win;
      ptag_q[0] <= req_tag_i[32'(win)*TAG_W +: TAG_W];
      for (int unsigned i = 1; i < LAT; i++) begin
        pid_q[i]  <= pid_q[i-1];
        ptag_q[i] <= ptag_q[i-1];
      end
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.data = core_out_i;
    push_entry.id   = SCHED_ID_W'(pid_q[LAT-1]);
    push_entry.tag  = SCHED_TAG_W'(ptag_q[LAT-1]);
  end

  aes_sched_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pv_q[LAT-1]),
    .wdata_i (push_entry),
    .pop_i   (rsp_ready_i),
    .rdata_o (head_entry),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rsp_valid_o = !fifo_empty;
  assign rsp_data_o  = head_entry.data;
  assign rsp_id_o    = ID_W'(head_entry.id);
  assign rsp_tag_o   = TAG_W'(head_entry.tag);

`ifdef AES_SCHED_KEY_RELOAD_EN
  sched_state_e state_q, state_d;
  logic [127:0] key_q, key_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      key_q   <= KEY_DEFAULT;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
    end
  end

  // Key swap waits for the pipe to empty; buffered results already carry the old key.
  always_comb begin
    state_d         = state_q;
    key_d           = key_q;
    key_upd_ready_o = 1'b0;
    unique case (state_q)
      RUN:     if (key_upd_valid_i) state_d = DRAIN;
      DRAIN:   if (pv_q == '0) state_d = LOAD;
      LOAD: begin
        key_d           = key_upd_data_i;
        key_upd_ready_o = 1'b1;
        state_d         = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign run_ok     = (state_q == RUN) && !key_upd_valid_i;
  assign core_key_o = key_q;
`else
  assign run_ok     = 1'b1;
  assign core_key_o = KEY_DEFAULT;
`endif

endmodule
